// File: rtl/spram_fifo_arb.sv
// FIFO held in one single-port 16-bit RAM. A one-entry write holding register and a
// write-priority port arbiter let callers enqueue and dequeue in the same cycle.
module spram_fifo_arb #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  write_strobe,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clear_overflow,
  input  logic                  read_strobe,
  output logic [WIDTH-1:0]      read_data,
  output logic                  read_valid,
  output logic                  data_available,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0]   C_FULL     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   C_CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   C_CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2
  } arb_t;

  logic [15:0]           r_mem [0:16383];
  logic [WIDTH-1:0]      r_ram_q;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [15:0]           r_wbuf;
  logic                  r_wbuf_valid;
  logic                  r_rd_pend;
  logic                  r_rd_fly;
  logic [WIDTH-1:0]      r_read_data;
  logic                  r_read_valid;
  logic                  r_overflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_we;
  logic [13:0]           w_addr;
  arb_t                  w_arb;

  assign full           = (r_count == C_FULL);
  assign data_available = (r_count != C_CNT_ZERO) && !r_rd_pend && !r_rd_fly;
  assign w_wr_acc       = write_strobe && !full;
  assign w_rd_acc       = read_strobe && data_available;
  assign overflow       = r_overflow;
  assign read_data      = r_read_data;
  assign read_valid     = r_read_valid;
  assign count          = r_count;

  // Single RAM port: draining the holding register always beats a pending read
  always_comb begin
    w_arb = ARB_IDLE;
    if (r_wbuf_valid) begin
      w_arb = ARB_WRITE;
    end else if (r_rd_pend) begin
      w_arb = ARB_READ;
    end else begin
      w_arb = ARB_IDLE;
    end
    w_we   = (w_arb == ARB_WRITE);
    w_addr = w_we ? 14'(r_wr_ptr) : 14'(r_rd_ptr);
  end

  // Single-port RAM with registered output; contents survive reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= r_wbuf;
    end else begin
      r_ram_q <= r_mem[w_addr][WIDTH-1:0];
    end
  end

  // Pointers, occupancy, holding register, read pipeline and overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr     <= {DEPTH_LOG2{1'b0}};
      r_count      <= C_CNT_ZERO;
      r_wbuf       <= 16'h0000;
      r_wbuf_valid <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_fly     <= 1'b0;
      r_read_data  <= {WIDTH{1'b0}};
      r_read_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wbuf       <= 16'(write_data);
        r_wbuf_valid <= 1'b1;
      end else if (w_arb == ARB_WRITE) begin
        r_wbuf_valid <= 1'b0;
      end
      if (w_arb == ARB_WRITE) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_pend <= 1'b1;
      end else if (w_arb == ARB_READ) begin
        r_rd_pend <= 1'b0;
      end
      if (w_arb == ARB_READ) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_rd_fly     <= (w_arb == ARB_READ);
      r_read_valid <= r_rd_fly;
      if (r_rd_fly) begin
        r_read_data <= r_ram_q;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A dropped write outranks a same-cycle clear
      if (write_strobe && full) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spram_fifo_arb.sv
// Scoreboard bench for spram_fifo_arb: a queue-based reference decides acceptance and
// expected data/latency; a negedge monitor pops and checks every read_valid pulse.
module tb_spram_fifo_arb;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int CAP = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] write_data = '0;
  logic         write_strobe = 1'b0;
  logic         full;
  logic         overflow;
  logic         clear_overflow = 1'b0;
  logic         read_strobe = 1'b0;
  logic [W-1:0] read_data;
  logic         read_valid;
  logic         data_available;
  logic [D:0]   count;

  spram_fifo_arb #(.WIDTH(W), .DEPTH_LOG2(D)) dut (
    .clk(clk), .reset(reset), .write_data(write_data), .write_strobe(write_strobe),
    .full(full), .overflow(overflow), .clear_overflow(clear_overflow),
    .read_strobe(read_strobe), .read_data(read_data), .read_valid(read_valid),
    .data_available(data_available), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int iss;
  } rd_t;

  int  total = 0;
  int  bad = 0;
  int  mq[$];
  rd_t sb[$];
  bit  wacc_edge[int];
  int  n_issued = 0;
  int  n_seen = 0;
  bit  movf = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every read_valid pulse must match the oldest outstanding expected read
  always @(negedge clk) begin
    rd_t r;
    int  e;
    if (!reset && read_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_read_valid", 1, 0);
      end else begin
        r = sb.pop_front();
        e = r.iss + 1;
        while (wacc_edge.exists(e - 1)) e++;
        chk("read_data", int'(read_data), r.data);
        chk("read_latency_edge", cyc, e + 1);
        n_seen++;
      end
    end
  end

  function automatic bit model_avail();
    return (mq.size() != 0) && (n_issued == n_seen);
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model
  task automatic step(input bit ws, input int wd, input bit rs, input bit co);
    bit avail, wacc, racc;
    rd_t r;
    avail = model_avail();
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == CAP));
    chk("data_available", int'(data_available), int'(avail));
    chk("overflow", int'(overflow), int'(movf));
    write_strobe   = ws;
    write_data     = W'(wd);
    read_strobe    = rs;
    clear_overflow = co;
    wacc = ws && (mq.size() < CAP);
    racc = rs && avail;
    if (racc) begin
      r.data = mq.pop_front();
      r.iss  = cyc + 1;
      sb.push_back(r);
      n_issued++;
    end
    if (wacc) begin
      mq.push_back(wd & 8'hFF);
      wacc_edge[cyc + 1] = 1'b1;
    end
    if (ws && !wacc) movf = 1'b1;
    else if (co) movf = 1'b0;
    @(negedge clk);
    #1;
    write_strobe   = 1'b0;
    read_strobe    = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && !(mq.size() == 0 && n_issued == n_seen); i++) begin
      step(1'b0, 0, model_avail(), 1'b0);
    end
    chk("drain_complete", mq.size() + (n_issued - n_seen), 0);
  endtask

  initial begin
    int base, written;
    bit ws, rs;

    #12;
    chk("reset_count", int'(count), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_data_available", int'(data_available), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_read_valid", int'(read_valid), 0);
    chk("reset_read_data", int'(read_data), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Basic ordering and 2-cycle read latency
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    drain();

    // Simultaneous write and read with one entry held
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b1, 1'b0);
    drain();

    // Fill, dropped writes (set beats clear, drop alongside a read), drain, clear
    for (int i = 0; i < CAP; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    drain();
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);

    // Read stalled by five consecutive writes winning the port
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 8'h60, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) step(1'b1, 8'h60 + i, 1'b0, 1'b0);
    drain();

    // Randomised wrap-around: 40 incrementing writes, occupancy kept at most 12
    base = int'($urandom_range(0, 255));
    written = 0;
    for (int i = 0; i < 2000 && !(written == 40 && mq.size() == 0 && n_issued == n_seen); i++) begin
      ws = (written < 40) && (mq.size() < 12) && ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 1) == 1) && (mq.size() > 1 || written == 40);
      step(ws, base + written, rs, $urandom_range(0, 7) == 0);
      if (ws) written++;
    end
    chk("random_writes_done", written, 40);
    drain();

    // Asynchronous reset while a read is in flight
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midread_reset_read_data", int'(read_data), 0);
    chk("midread_reset_count", int'(count), 0);
    chk("midread_reset_read_valid", int'(read_valid), 0);
    chk("midread_reset_data_available", int'(data_available), 0);
    mq.delete();
    sb.delete();
    n_issued = n_seen;
    movf = 1'b0;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0, 1'b0);
    chk("no_outstanding_reads", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
